// File: rtl/lane_object_motion.sv
// ---------------------------------------------------------------------------------------------
// lane_object_motion
//
// Motion engine for a single lane sprite (car or lilypad). The X position advances once per
// video frame and wraps around horizontally. The geometry buses feed color_mapper directly.
// The position is held while the object is idle or paused. The speed can be changed at runtime
// through a valid/ready handshake.
//
// Optional build macro: LANE_OBJECT_MOTION_DIVIDER_EN
//   When this macro is defined, the module gains a FRAME_DIV parameter and a 4-bit frame
//   counter. A position update then happens only on every (FRAME_DIV+1)th tick in RUN.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous active-low reset
//   frame_clk    in   vertical-sync-rate clock, asynchronous to Clk
//   Start        in   level, IDLE -> RUN
//   Pause        in   level, RUN <-> HOLD
//   Restart      in   pulse, back to IDLE with ObjX = START_X
//   Speed_valid  in   new speed offered
//   Speed[3:0]   in   offered speed in pixels per step
//   Speed_ready  out  a new speed can be accepted
//   ObjX[10:0]   out  top-left X, two's complement modulo 2048
//   ObjY[10:0]   out  constant LANE_Y
//   Obj_Width    out  constant WIDTH
//   Obj_Height   out  constant HEIGHT
//   Step         out  one-cycle pulse when a position update is applied
//   Wrapped      out  one-cycle pulse, coincident with Step, when that update wrapped
// ---------------------------------------------------------------------------------------------
module lane_object_motion #(
   parameter logic [10:0] START_X       = 11'd0,
   parameter logic [10:0] LANE_Y        = 11'd240,
   parameter logic [10:0] WIDTH         = 11'd64,
   parameter logic [10:0] HEIGHT        = 11'd32,
   parameter logic [10:0] SCREEN_W      = 11'd640,
   parameter bit          DIR_LEFT      = 1'b0,
   parameter logic [3:0]  DEFAULT_SPEED = 4'd2
`ifdef LANE_OBJECT_MOTION_DIVIDER_EN
   ,
   parameter logic [3:0]  FRAME_DIV     = 4'd1
`endif
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        Start,
   input  logic        Pause,
   input  logic        Restart,
   input  logic        Speed_valid,
   input  logic [3:0]  Speed,
   output logic        Speed_ready,
   output logic [10:0] ObjX,
   output logic [10:0] ObjY,
   output logic [10:0] Obj_Width,
   output logic [10:0] Obj_Height,
   output logic        Step,
   output logic        Wrapped
);

   // 2048 - WIDTH: the sprite sits fully off-screen to the left.
   localparam logic [10:0] NEG_WIDTH = 11'd0 - WIDTH;

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e      r_state;
   logic        r_fs1, r_fs2, r_fs3, r_tick;
   logic [10:0] r_obj_x;
   logic [3:0]  r_speed;
   logic [3:0]  r_pend_speed;
   logic        r_pend_vld;
   logic        r_step;
   logic        r_wrapped;

   logic        w_xfer;
   logic        w_div_hit;
   logic [3:0]  w_eff_speed;
   logic [10:0] w_nx;
   logic        w_wrap;
   logic [10:0] w_new_x;

   // The frame_clk input passes through two synchronizer flops. A third flop provides the
   // previous value for rising-edge detection. The tick is registered, so it is high for
   // exactly one cycle, 3 Clk edges after the frame_clk rise.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_fs1  <= 1'b0;
         r_fs2  <= 1'b0;
         r_fs3  <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_fs1  <= frame_clk;
         r_fs2  <= r_fs1;
         r_fs3  <= r_fs2;
         r_tick <= r_fs2 & ~r_fs3;
      end
   end

   // A transfer can only happen while no speed is pending.
   assign w_xfer = Speed_valid & ~r_pend_vld;

   // A pending speed takes effect ahead of the position math of the tick that applies it.
   assign w_eff_speed = r_pend_vld ? r_pend_speed : r_speed;

`ifdef LANE_OBJECT_MOTION_DIVIDER_EN
   logic [3:0] r_div_cnt;
   assign w_div_hit = (r_div_cnt == FRAME_DIV);
`else
   assign w_div_hit = 1'b1;
`endif

   always_comb begin
      w_wrap = 1'b0;
      if (DIR_LEFT) begin
         w_nx = r_obj_x - {7'd0, w_eff_speed};
         if ((w_eff_speed != 4'd0) && ($signed(w_nx) <= $signed(NEG_WIDTH))) begin
            w_wrap = 1'b1;
         end
      end else begin
         w_nx = r_obj_x + {7'd0, w_eff_speed};
         // Values at or above 1024 are the negative (partially visible) region. They are
         // not treated as past the right edge.
         if ((w_eff_speed != 4'd0) && (w_nx >= SCREEN_W) && (w_nx < 11'd1024)) begin
            w_wrap = 1'b1;
         end
      end
      if (w_wrap) begin
         w_new_x = DIR_LEFT ? SCREEN_W : NEG_WIDTH;
      end else begin
         w_new_x = w_nx;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= StIdle;
         r_obj_x      <= START_X;
         r_speed      <= DEFAULT_SPEED;
         r_pend_speed <= 4'd0;
         r_pend_vld   <= 1'b0;
         r_step       <= 1'b0;
         r_wrapped    <= 1'b0;
`ifdef LANE_OBJECT_MOTION_DIVIDER_EN
         r_div_cnt    <= 4'd0;
`endif
      end else begin
         r_step    <= 1'b0;
         r_wrapped <= 1'b0;
         if (Restart) begin
            // Restart overrides Start, Pause and tick in the same cycle.
            r_state    <= StIdle;
            r_obj_x    <= START_X;
            r_pend_vld <= 1'b0;
`ifdef LANE_OBJECT_MOTION_DIVIDER_EN
            r_div_cnt  <= 4'd0;
`endif
         end else begin
            if (w_xfer) begin
               r_pend_vld   <= 1'b1;
               r_pend_speed <= Speed;
            end
            case (r_state)
               StIdle: begin
                  if (Start) begin
                     r_state <= StRun;
                  end
               end
               StRun: begin
                  if (Pause) begin
                     // A tick that arrives together with Pause is dropped.
                     r_state <= StHold;
                  end else if (r_tick) begin
`ifdef LANE_OBJECT_MOTION_DIVIDER_EN
                     r_div_cnt <= w_div_hit ? 4'd0 : r_div_cnt + 4'd1;
`endif
                     if (w_div_hit) begin
                        r_obj_x   <= w_new_x;
                        r_step    <= 1'b1;
                        r_wrapped <= w_wrap;
                        // w_xfer is 0 whenever r_pend_vld is 1, so this cannot conflict
                        // with the latch above.
                        if (r_pend_vld) begin
                           r_speed    <= r_pend_speed;
                           r_pend_vld <= 1'b0;
                        end
                     end
                  end
               end
               StHold: begin
                  if (!Pause) begin
                     r_state <= StRun;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign Speed_ready = ~r_pend_vld;
   assign ObjX        = r_obj_x;
   assign ObjY        = LANE_Y;
   assign Obj_Width   = WIDTH;
   assign Obj_Height  = HEIGHT;
   assign Step        = r_step;
   assign Wrapped     = r_wrapped;

endmodule

// File: tb/tb_lane_object_motion.sv
// ---------------------------------------------------------------------------------------------
// tb_lane_object_motion
//
// Directed bench with three instances:
//   u_dut_r : default right mover (START_X 0, speed 2)
//   u_dut_w : right mover placed near the right edge (START_X 632, speed 3)
//   u_dut_l : left mover placed near the left edge (START_X 1990 = -58, speed 2)
// Pause, Restart, Reset and frame_clk are shared; Start and Speed_valid are per instance.
// ---------------------------------------------------------------------------------------------
module tb_lane_object_motion;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic       pause = 1'b0;
   logic       restart = 1'b0;
   logic [3:0] speed = 4'd0;
   logic       start_r = 1'b0, start_w = 1'b0, start_l = 1'b0;
   logic       valid_r = 1'b0, valid_w = 1'b0, valid_l = 1'b0;

   logic [10:0] x_r, y_r, wd_r, ht_r, x_w, y_w, wd_w, ht_w, x_l, y_l, wd_l, ht_l;
   logic        rdy_r, step_r, wrap_r, rdy_w, step_w, wrap_w, rdy_l, step_l, wrap_l;

   int n_checks = 0;
   int n_errors = 0;
   int n_step_r = 0;
   int n_wrap_r = 0;
   logic s3_step_r;

   always #5 clk = ~clk;

   lane_object_motion u_dut_r (
      .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .Start(start_r), .Pause(pause),
      .Restart(restart), .Speed_valid(valid_r), .Speed(speed), .Speed_ready(rdy_r),
      .ObjX(x_r), .ObjY(y_r), .Obj_Width(wd_r), .Obj_Height(ht_r), .Step(step_r),
      .Wrapped(wrap_r)
   );

   lane_object_motion #(.START_X(11'd632), .DEFAULT_SPEED(4'd3)) u_dut_w (
      .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .Start(start_w), .Pause(pause),
      .Restart(restart), .Speed_valid(valid_w), .Speed(speed), .Speed_ready(rdy_w),
      .ObjX(x_w), .ObjY(y_w), .Obj_Width(wd_w), .Obj_Height(ht_w), .Step(step_w),
      .Wrapped(wrap_w)
   );

   lane_object_motion #(.START_X(11'd1990), .DIR_LEFT(1'b1)) u_dut_l (
      .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .Start(start_l), .Pause(pause),
      .Restart(restart), .Speed_valid(valid_l), .Speed(speed), .Speed_ready(rdy_l),
      .ObjX(x_l), .ObjY(y_l), .Obj_Width(wd_l), .Obj_Height(ht_l), .Step(step_l),
      .Wrapped(wrap_l)
   );

   always @(posedge clk) begin
      if (step_r) n_step_r <= n_step_r + 1;
      if (wrap_r) n_wrap_r <= n_wrap_r + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Raise frame_clk between edges. Return #1 after the 4th following posedge, which is
   // where the Step produced by this frame is expected.
   task automatic frame_rise();
      @(negedge clk);
      frame_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      s3_step_r = step_r;
      @(posedge clk);
      #1;
   endtask

   task automatic frame_fall();
      repeat (3) @(negedge clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame();
      frame_rise();
      frame_fall();
   endtask

   initial begin
      // Reset held low: outputs at reset values.
      repeat (3) @(negedge clk);
      check_eq("rst_x", 32'(x_r), 32'd0);
      check_eq("rst_step", 32'(step_r), 32'd0);
      check_eq("rst_rdy", 32'(rdy_r), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("const_y", 32'(y_r), 32'd240);
      check_eq("const_w", 32'(wd_r), 32'd64);
      check_eq("const_h", 32'(ht_r), 32'd32);
      check_eq("rst_x_w", 32'(x_w), 32'd632);
      check_eq("rst_x_l", 32'(x_l), 32'd1990);

      // Idle for 5 frames: no movement and no Step pulses.
      repeat (5) frame();
      check_eq("idle_x", 32'(x_r), 32'd0);
      check_eq("idle_steps", 32'(n_step_r), 32'd0);

      // Edge instances: two plain steps, then the wrap step.
      @(negedge clk);
      start_w = 1'b1;
      start_l = 1'b1;
      frame_rise();
      check_eq("w_f1_x", 32'(x_w), 32'd635);
      check_eq("l_f1_x", 32'(x_l), 32'd1988);
      check_eq("w_f1_wrap", 32'(wrap_w), 32'd0);
      frame_fall();
      frame_rise();
      check_eq("w_f2_x", 32'(x_w), 32'd638);
      check_eq("l_f2_x", 32'(x_l), 32'd1986);
      check_eq("l_f2_wrap", 32'(wrap_l), 32'd0);
      frame_fall();
      frame_rise();
      check_eq("w_wrap_x", 32'(x_w), 32'd1984);
      check_eq("w_wrap", 32'(wrap_w), 32'd1);
      check_eq("w_wrap_step", 32'(step_w), 32'd1);
      check_eq("l_wrap_x", 32'(x_l), 32'd640);
      check_eq("l_wrap", 32'(wrap_l), 32'd1);
      frame_fall();
      // Change the right mover to speed 2 for the step that follows the wrap.
      @(negedge clk);
      speed = 4'd2;
      valid_w = 1'b1;
      @(posedge clk);
      #1;
      check_eq("w_rdy_low", 32'(rdy_w), 32'd0);
      @(negedge clk);
      valid_w = 1'b0;
      frame_rise();
      check_eq("w_after_x", 32'(x_w), 32'd1986);
      check_eq("w_after_wrap", 32'(wrap_w), 32'd0);
      check_eq("w_after_rdy", 32'(rdy_w), 32'd1);
      check_eq("l_after_x", 32'(x_l), 32'd638);
      frame_fall();
      @(negedge clk);
      start_w = 1'b0;
      start_l = 1'b0;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check_eq("w_restart_x", 32'(x_w), 32'd632);
      check_eq("l_restart_x", 32'(x_l), 32'd1990);

      // Main right mover: 10 frames at speed 2.
      @(negedge clk);
      start_r = 1'b1;
      for (int i = 0; i < 10; i++) begin
         frame_rise();
         check_eq("run_step_early", 32'(s3_step_r), 32'd0);
         check_eq("run_step", 32'(step_r), 32'd1);
         check_eq("run_x", 32'(x_r), 32'(2 * (i + 1)));
         frame_fall();
      end
      check_eq("run_steps", 32'(n_step_r), 32'd10);
      check_eq("run_wraps", 32'(n_wrap_r), 32'd0);

      // Speed 7 offered mid-frame while in RUN.
      @(negedge clk);
      speed = 4'd7;
      valid_r = 1'b1;
      @(posedge clk);
      #1;
      check_eq("hs_rdy_low", 32'(rdy_r), 32'd0);
      @(negedge clk);
      valid_r = 1'b0;
      frame_rise();
      check_eq("hs_x", 32'(x_r), 32'd27);
      check_eq("hs_rdy_back", 32'(rdy_r), 32'd1);
      frame_fall();

      // Offer speed 5 in HOLD: the value stays pending across 3 frames.
      @(negedge clk);
      pause = 1'b1;
      @(negedge clk);
      speed = 4'd5;
      valid_r = 1'b1;
      @(negedge clk);
      valid_r = 1'b0;
      repeat (3) frame();
      check_eq("hold_x", 32'(x_r), 32'd27);
      check_eq("hold_steps", 32'(n_step_r), 32'd11);
      check_eq("hold_rdy", 32'(rdy_r), 32'd0);
      @(negedge clk);
      pause = 1'b0;
      frame_rise();
      check_eq("unhold_x", 32'(x_r), 32'd32);
      check_eq("unhold_rdy", 32'(rdy_r), 32'd1);
      frame_fall();

      // Restart coincident with a tick, with speed 9 pending.
      @(negedge clk);
      speed = 4'd9;
      valid_r = 1'b1;
      @(negedge clk);
      valid_r = 1'b0;
      check_eq("rs_rdy_low", 32'(rdy_r), 32'd0);
      frame_clk = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      restart = 1'b1;
      start_r = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rs_step", 32'(step_r), 32'd0);
      check_eq("rs_x", 32'(x_r), 32'd0);
      check_eq("rs_rdy", 32'(rdy_r), 32'd1);
      @(negedge clk);
      restart = 1'b0;
      frame_fall();
      frame();
      check_eq("rs_idle_x", 32'(x_r), 32'd0);
      // The discarded 9 must not be applied; the active speed is still 5.
      @(negedge clk);
      start_r = 1'b1;
      frame_rise();
      check_eq("rs_resume_x", 32'(x_r), 32'd5);
      frame_fall();

      // Async reset while Step is high, between clock edges.
      frame_rise();
      check_eq("ar_pre_x", 32'(x_r), 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_x", 32'(x_r), 32'd0);
      check_eq("ar_step", 32'(step_r), 32'd0);
      check_eq("ar_rdy", 32'(rdy_r), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
